// File: rtl/nco_mch_pkg.sv
// Shared constants and helpers for the multi-channel NCO: pipeline depth,
// quadrant encoding and the quarter-wave ROM contents.
package nco_mch_pkg;

    localparam int LATENCY = 4;

    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    localparam real PI = 3.14159265358979323846;

    // Odd quadrants walk the quarter wave backwards.
    function automatic logic quad_mirror(input logic [1:0] q);
        return (q == QUAD_1) || (q == QUAD_3);
    endfunction

    function automatic logic quad_negative(input logic [1:0] q);
        return !((q == QUAD_0) || (q == QUAD_1));
    endfunction

    // Half-bin offset keeps the table symmetric so no entry is exactly zero.
    function automatic int rom_entry(input int idx, input int out_w, input int lut_aw);
        real amp;
        real ang;
        amp = real'((1 << (out_w - 1)) - 1);
        ang = (real'(idx) + 0.5) * PI / real'(1 << (lut_aw + 1));
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/nco_mch_if.sv
// Configuration bus of the multi-channel NCO: shadow-register writes and the
// update strobe that commits them.
interface nco_mch_if #(
    parameter int PHASE_W = 32
);
    logic               cfg_we;
    logic               cfg_sel;
    logic [2:0]         cfg_ch;
    logic [PHASE_W-1:0] cfg_data;
    logic               update;

    modport master (
        output cfg_we,
        output cfg_sel,
        output cfg_ch,
        output cfg_data,
        output update
    );

    modport slave (
        input cfg_we,
        input cfg_sel,
        input cfg_ch,
        input cfg_data,
        input update
    );
endinterface

// File: rtl/nco_mch_chan.sv
// One NCO channel: active increment/offset, phase accumulator and a 4-stage
// sine/cosine pipeline reading a private quarter-wave ROM.
module nco_mch_chan
    import nco_mch_pkg::*;
#(
    parameter int                 PHASE_W     = 32,
    parameter int                 OUT_W       = 14,
    parameter int                 LUT_AW      = 10,
    parameter logic [PHASE_W-1:0] PHI_DEFAULT = 32'h020C49BA
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clken,
    input  logic                     sync,
    input  logic                     load,
    input  logic [PHASE_W-1:0]       inc_load,
    input  logic [PHASE_W-1:0]       off_load,
    output logic signed [OUT_W-1:0]  sin_o,
    output logic signed [OUT_W-1:0]  cos_o
);

    localparam int PW = LUT_AW + 2;

    logic [PHASE_W-1:0] acc_reg;
    logic [PHASE_W-1:0] inc_reg;
    logic [PHASE_W-1:0] off_reg;
    logic [PHASE_W-1:0] phase_sum;
    logic [PW-1:0]      phase_reg;
    logic [1:0]         quad_sin;
    logic [1:0]         quad_cos;
    logic [LUT_AW-1:0]  frac;
    logic [LUT_AW-1:0]  addr_sin_reg;
    logic [LUT_AW-1:0]  addr_cos_reg;
    logic               neg_sin_s2_reg;
    logic               neg_cos_s2_reg;
    logic               neg_sin_s3_reg;
    logic               neg_cos_s3_reg;
    logic [OUT_W-2:0]   rom_sin_reg;
    logic [OUT_W-2:0]   rom_cos_reg;

    logic [OUT_W-2:0]   rom [2**LUT_AW];

    for (genvar gi = 0; gi < 2**LUT_AW; gi++) begin : g_rom
        assign rom[gi] = (OUT_W-1)'(rom_entry(gi, OUT_W, LUT_AW));
    end

    assign phase_sum = acc_reg + off_reg;
    assign quad_sin  = phase_reg[PW-1 -: 2];
    assign quad_cos  = quad_sin + 2'd1;
    assign frac      = phase_reg[LUT_AW-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inc_reg <= PHI_DEFAULT;
            off_reg <= '0;
        end else if (load) begin
            inc_reg <= inc_load;
            off_reg <= off_load;
        end
    end

    // Offset is applied at S1, so a mid-stream update never touches samples in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_reg        <= '0;
            phase_reg      <= '0;
            addr_sin_reg   <= '0;
            addr_cos_reg   <= '0;
            neg_sin_s2_reg <= 1'b0;
            neg_cos_s2_reg <= 1'b0;
            neg_sin_s3_reg <= 1'b0;
            neg_cos_s3_reg <= 1'b0;
            rom_sin_reg    <= '0;
            rom_cos_reg    <= '0;
            sin_o          <= '0;
            cos_o          <= '0;
        end else if (clken) begin
            acc_reg        <= sync ? '0 : acc_reg + inc_reg;
            phase_reg      <= phase_sum[PHASE_W-1 -: PW];
            addr_sin_reg   <= quad_mirror(quad_sin) ? ~frac : frac;
            addr_cos_reg   <= quad_mirror(quad_cos) ? ~frac : frac;
            neg_sin_s2_reg <= quad_negative(quad_sin);
            neg_cos_s2_reg <= quad_negative(quad_cos);
            rom_sin_reg    <= rom[addr_sin_reg];
            rom_cos_reg    <= rom[addr_cos_reg];
            neg_sin_s3_reg <= neg_sin_s2_reg;
            neg_cos_s3_reg <= neg_cos_s2_reg;
            sin_o          <= neg_sin_s3_reg ? -$signed({1'b0, rom_sin_reg}) : $signed({1'b0, rom_sin_reg});
            cos_o          <= neg_cos_s3_reg ? -$signed({1'b0, rom_cos_reg}) : $signed({1'b0, rom_cos_reg});
        end
    end

endmodule

// File: rtl/nco_mch.sv
// Multi-channel NCO top: shadow registers and config decode, NUM_CH channel
// pipelines and the output-valid counter.
module nco_mch
    import nco_mch_pkg::*;
#(
    parameter int                 NUM_CH      = 4,
    parameter int                 PHASE_W     = 32,
    parameter int                 OUT_W       = 14,
    parameter int                 LUT_AW      = 10,
    parameter logic [PHASE_W-1:0] PHI_DEFAULT = 32'h020C49BA
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    nco_mch_if.slave                cfg,
    input  logic                    sync,
    output logic                    out_valid,
    output logic [NUM_CH*OUT_W-1:0] fsin_o,
    output logic [NUM_CH*OUT_W-1:0] fcos_o
);

    logic [2:0] valid_cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_cnt_reg <= '0;
        end else if (clken && valid_cnt_reg != 3'd7) begin
            valid_cnt_reg <= valid_cnt_reg + 3'd1;
        end
    end

    assign out_valid = (valid_cnt_reg >= 3'(LATENCY));

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [PHASE_W-1:0] inc_shadow_reg;
        logic [PHASE_W-1:0] off_shadow_reg;
        logic [PHASE_W-1:0] inc_next;
        logic [PHASE_W-1:0] off_next;
        logic               hit_inc;
        logic               hit_off;

        assign hit_inc  = cfg.cfg_we && !cfg.cfg_sel && (cfg.cfg_ch == 3'(gi));
        assign hit_off  = cfg.cfg_we &&  cfg.cfg_sel && (cfg.cfg_ch == 3'(gi));
        // A write landing with update goes straight through to the active register.
        assign inc_next = hit_inc ? cfg.cfg_data : inc_shadow_reg;
        assign off_next = hit_off ? cfg.cfg_data : off_shadow_reg;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                inc_shadow_reg <= PHI_DEFAULT;
                off_shadow_reg <= '0;
            end else begin
                inc_shadow_reg <= inc_next;
                off_shadow_reg <= off_next;
            end
        end

        nco_mch_chan #(
            .PHASE_W     (PHASE_W),
            .OUT_W       (OUT_W),
            .LUT_AW      (LUT_AW),
            .PHI_DEFAULT (PHI_DEFAULT)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .clken    (clken),
            .sync     (sync),
            .load     (cfg.update),
            .inc_load (inc_next),
            .off_load (off_next),
            .sin_o    (fsin_o[gi*OUT_W +: OUT_W]),
            .cos_o    (fcos_o[gi*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_nco_mch.sv
// Self-checking bench for nco_mch: behavioural model feeding a scoreboard,
// a vector table for the quarter-rate channel and hand-written corner sequences.
module tb_nco_mch;

    localparam int          NUM_CH = 4;
    localparam int          OUT_W  = 14;
    localparam logic [31:0] PHI    = 32'h020C49BA;
    localparam real         TB_PI  = 3.14159265358979323846;

    typedef struct packed {
        logic [NUM_CH*OUT_W-1:0] s;
        logic [NUM_CH*OUT_W-1:0] c;
    } exp_t;

    typedef struct packed {
        logic                    ce;
        logic signed [OUT_W-1:0] s;
        logic signed [OUT_W-1:0] c;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic clken;
    logic sync;
    logic out_valid;
    logic [NUM_CH*OUT_W-1:0] fsin_o;
    logic [NUM_CH*OUT_W-1:0] fcos_o;

    nco_mch_if #(.PHASE_W(32)) cfg_bus ();

    nco_mch #(
        .NUM_CH      (NUM_CH),
        .PHASE_W     (32),
        .OUT_W       (OUT_W),
        .LUT_AW      (10),
        .PHI_DEFAULT (PHI)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .cfg       (cfg_bus),
        .sync      (sync),
        .out_valid (out_valid),
        .fsin_o    (fsin_o),
        .fcos_o    (fcos_o)
    );

    always #5 clk = ~clk;

    logic [31:0] m_acc   [NUM_CH];
    logic [31:0] m_inc_a [NUM_CH];
    logic [31:0] m_off_a [NUM_CH];
    logic [31:0] m_inc_s [NUM_CH];
    logic [31:0] m_off_s [NUM_CH];
    int          ce_cnt;
    int          lut_tab [1024];
    exp_t        sb [$];
    exp_t        last_exp;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tv [12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] wave(input logic [31:0] p, input bit cosine);
        int k, q, a, v;
        k = int'(p[31:20]);
        if (cosine) k = (k + 1024) % 4096;
        q = k / 1024;
        a = k % 1024;
        v = (q % 2 == 1) ? lut_tab[1023 - a] : lut_tab[a];
        if (q >= 2) v = -v;
        return OUT_W'(v);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_acc[c]   = '0;
            m_inc_a[c] = PHI;
            m_inc_s[c] = PHI;
            m_off_a[c] = '0;
            m_off_s[c] = '0;
        end
        ce_cnt = 0;
        sb.delete();
    endtask

    task automatic model_edge();
        exp_t e;
        if (!reset_n) begin
            model_reset();
        end else begin
            if (clken) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    e.s[c*OUT_W +: OUT_W] = wave(m_acc[c] + m_off_a[c], 1'b0);
                    e.c[c*OUT_W +: OUT_W] = wave(m_acc[c] + m_off_a[c], 1'b1);
                    m_acc[c] = sync ? 32'd0 : m_acc[c] + m_inc_a[c];
                end
                sb.push_back(e);
                if (ce_cnt < 7) ce_cnt++;
            end
            if (cfg_bus.cfg_we && int'(cfg_bus.cfg_ch) < NUM_CH) begin
                if (cfg_bus.cfg_sel) m_off_s[cfg_bus.cfg_ch] = cfg_bus.cfg_data;
                else                 m_inc_s[cfg_bus.cfg_ch] = cfg_bus.cfg_data;
            end
            if (cfg_bus.update) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    m_inc_a[c] = m_inc_s[c];
                    m_off_a[c] = m_off_s[c];
                end
            end
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (!reset_n) begin
            chk("reset_sin", 64'(fsin_o), 64'd0);
            chk("reset_cos", 64'(fcos_o), 64'd0);
            chk("reset_valid", 64'(out_valid), 64'd0);
        end else begin
            chk("out_valid", 64'(out_valid), 64'(ce_cnt >= 4));
            if (ce_cnt >= 4) begin
                if (clken) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_empty: got no expected sample, required one queued");
                    end else begin
                        e = sb.pop_front();
                        last_exp = e;
                        chk("sb_sin", 64'(fsin_o), 64'(e.s));
                        chk("sb_cos", 64'(fcos_o), 64'(e.c));
                    end
                end else begin
                    chk("hold_sin", 64'(fsin_o), 64'(last_exp.s));
                    chk("hold_cos", 64'(fcos_o), 64'(last_exp.c));
                end
            end
        end
    endtask

    task automatic step(input logic rst_n, input logic ce, input logic sy, input logic we,
                        input logic sel, input logic [2:0] ch, input logic [31:0] data,
                        input logic up);
        reset_n          = rst_n;
        clken            = ce;
        sync             = sy;
        cfg_bus.cfg_we   = we;
        cfg_bus.cfg_sel  = sel;
        cfg_bus.cfg_ch   = ch;
        cfg_bus.cfg_data = data;
        cfg_bus.update   = up;
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run(input int n, input logic ce);
        for (int i = 0; i < n; i++) step(1'b1, ce, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    endtask

    initial begin
        int c1, c2, idx;
        logic signed [OUT_W-1:0] prev, cur;

        for (int i = 0; i < 1024; i++)
            lut_tab[i] = $rtoi(8191.0 * $sin((real'(i) + 0.5) * TB_PI / 2048.0) + 0.5);

        // ch1 after sync with inc = quarter turn; clken=0 rows must hold the previous value
        tv[0]  = '{1'b1,  14'sd6,    14'sd8191};
        tv[1]  = '{1'b0,  14'sd6,    14'sd8191};
        tv[2]  = '{1'b1,  14'sd8191, -14'sd6};
        tv[3]  = '{1'b1, -14'sd6,    -14'sd8191};
        tv[4]  = '{1'b0, -14'sd6,    -14'sd8191};
        tv[5]  = '{1'b0, -14'sd6,    -14'sd8191};
        tv[6]  = '{1'b1, -14'sd8191,  14'sd6};
        tv[7]  = '{1'b1,  14'sd6,     14'sd8191};
        tv[8]  = '{1'b1,  14'sd8191, -14'sd6};
        tv[9]  = '{1'b0,  14'sd8191, -14'sd6};
        tv[10] = '{1'b1, -14'sd6,    -14'sd8191};
        tv[11] = '{1'b1, -14'sd8191,  14'sd6};

        model_reset();
        last_exp = '0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);

        // Default frequency from reset: first sample and sine period
        c1 = -1; c2 = -1; idx = 0; prev = '0;
        for (int i = 0; i < 264; i++) begin
            run(1, 1'b1);
            if (i == 3) begin
                chk("ch0_first_sin", 64'($signed(fsin_o[13:0])), 64'(6));
                chk("ch0_first_cos", 64'($signed(fcos_o[13:0])), 64'(8191));
            end
            if (i >= 3) begin
                cur = $signed(fsin_o[13:0]);
                if (i > 3 && prev < 0 && cur >= 0) begin
                    if (c1 < 0) c1 = idx;
                    else if (c2 < 0) c2 = idx;
                end
                prev = cur;
                idx++;
            end
        end
        chk("ch0_period", 64'(c2 - c1), 64'(125));

        // Write + update + sync in one cycle on ch1, then the gated vector table
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 32'h40000000, 1'b1);
        run(3, 1'b1);
        for (int i = 0; i < 12; i++) begin
            run(1, tv[i].ce);
            chk($sformatf("tv%0d_sin", i), 64'($signed(fsin_o[27:14])), 64'(tv[i].s));
            chk($sformatf("tv%0d_cos", i), 64'($signed(fcos_o[27:14])), 64'(tv[i].c));
        end

        // ch2 half-turn offset: sine must be the negation of ch0
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 32'h80000000, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        run(20, 1'b1);

        // Out-of-range channel write is ignored
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 32'h12345678, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 32'h12345678, 1'b1);
        run(10, 1'b1);

        // Randomly gated stream with mid-stream frequency/offset changes
        for (int i = 0; i < 80; i++) begin
            if (i == 20)
                step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 3'd3, $urandom, 1'b0);
            else if (i == 30)
                step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
            else if (i == 50)
                step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h3A000000, 1'b1);
            else if (i == 60)
                step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
            else
                run(1, 1'($urandom_range(0, 1)));
        end

        // Reset mid-stream, then the reset-release behaviour must repeat
        run(5, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run(1, 1'b1);
            if (i == 3) begin
                chk("restart_sin", 64'($signed(fsin_o[13:0])), 64'(6));
                chk("restart_cos", 64'($signed(fcos_o[13:0])), 64'(8191));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nco_mch.md
# nco_mch

Parametrised multi-channel numerically controlled oscillator that produces NUM_CH independent two's-complement sine/cosine pairs from one clock. Each channel has its own phase increment and phase offset, double-buffered so that frequency and phase changes land glitch-free on an `update` strobe, plus a common `sync` that phase-aligns all channels. It is the in-house successor to the single-channel 400 kHz vendor NCO and feeds the demodulation/reference paths of the acquisition chain.

## Interface
- NUM_CH, 4: number of channels (1..8)
- PHASE_W, 32: phase accumulator width
- OUT_W, 14: sin/cos output width, signed
- LUT_AW, 10: quarter-wave ROM address width (2^LUT_AW entries)
- PHI_DEFAULT, 32'h020C49BA: reset increment for every channel (400 kHz at 50 MHz clk, period 125 samples)

- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- clken  in  1  sample enable; pipeline and accumulators advance only when high
- cfg_we  in  1  write shadow register
- cfg_sel  in  1  0 = increment, 1 = phase offset
- cfg_ch  in  3  target channel; values >= NUM_CH ignored
- cfg_data  in  PHASE_W  write data
- update  in  1  copy all shadow registers to active registers
- sync  in  1  clear all accumulators (effective only with clken high)
- out_valid  out  1  outputs carry valid samples
- fsin_o  out  NUM_CH*OUT_W  sine, channel c at [c*OUT_W +: OUT_W]
- fcos_o  out  NUM_CH*OUT_W  cosine, same packing

## Operation
- Reset: accumulators 0, active/shadow increments PHI_DEFAULT, active/shadow offsets 0, all pipeline registers 0, fsin_o/fcos_o 0, out_valid 0.
- Config path ignores clken. cfg_we writes shadow[cfg_ch][cfg_sel]. update copies shadows to active regs in one edge; write and update in the same cycle: the written value is forwarded into the active register.
- Accumulator (clken=1): acc <= sync ? 0 : acc + inc_active, modulo 2^PHASE_W. sync and update together: accumulator cleared, new increment used from the next clken cycle.
- Phase p = acc + off_active (mod 2^PHASE_W), truncated to top LUT_AW+2 bits: q = p[MSB:MSB-1], a = next LUT_AW bits.
- ROM: lut[i] = round((2^(OUT_W-1)-1)*sin((i+0.5)*pi/2^(LUT_AW+1))), unsigned, OUT_W-1 bits.
- sin: q0 lut[a], q1 lut[~a], q2 -lut[a], q3 -lut[~a]. cos uses quadrant q+1 mod 4 with the same rule. No output ever reaches -2^(OUT_W-1).

## Timing
- 4-stage pipeline per channel, all stages gated by clken: S1 phase add, S2 quadrant decode/address mirror, S3 registered ROM read, S4 sign apply and output register.
- Latency: accumulator value present at clken edge n appears on outputs after clken edge n+4.
- out_valid: 3-bit saturating count of clken edges since reset release; out_valid=1 from the 4th clken edge on. First valid sample corresponds to acc=0. out_valid holds while clken=0.
- clken=0: all outputs and accumulators hold.
- update mid-stream: samples already in the pipeline finish with old offset; frequency change visible on the sample computed from the next accumulator step.
- reset_n low mid-operation: everything returns to reset values on the next edge; out_valid drops the same edge.

## Structure
- Package nco_mch_pkg: LATENCY=4, quadrant encoding constants, ROM init function (computed from OUT_W/LUT_AW).
- Sub-module nco_mch_chan: one channel's accumulator, active registers and 4-stage pipeline with a private quarter-wave ROM; top instantiates NUM_CH copies plus shadow registers, config decode and valid counter.

## Test plan
- Reset release, clken=1, defaults: out_valid rises after 4th edge; ch0 sin period exactly 125 samples, first sin=6, first cos=8191.
- Ch1 inc=32'h40000000, update, sync: sin sequence 6, 8191, -6, -8191; cos 8191, -6, -8191, 6, repeating.
- Ch2 offset=32'h80000000 with same inc as ch0: ch2 sin = -ch0 sin sample-for-sample.
- clken toggled 1/0 pattern: output sequence identical to continuous run, values held during clken=0.
- cfg_we with cfg_ch=7 (NUM_CH=4): no register changes; write+update same cycle: new increment used on next step.
- Assert reset_n mid-stream: outputs 0, out_valid 0 next edge; restart reproduces first test.
